// File: rtl/memory_stage_pipelined.sv
// memory_stage_pipelined: MEM stage of the 5-stage RISC-V pipeline plus the MEM/WB register.
// Holds a byte-addressable data memory, N_LED memory-mapped LED banks and N_SW
// switch banks with two-flop synchronisers. It also handles stall and flush, and
// reports misaligned accesses and accesses to unmapped addresses to WB.
//
// Ports:
//   clk_me, rst_n_me          stage clock (rising edge), async active-low reset
//   valid_me/stall_me/flush_me  pipeline control for the instruction in MEM
//   pc_next_me, ALU_res_me    PC+4 and effective address / ALU result
//   RU_rs2_me, dm_ctrl_me     store data, funct3 access size / sign
//   rd_me, RU_DM_write_src_me, RUwrite_me, dm_wr_me   control passed to WB / store enable
//   switches                  raw asynchronous switch inputs (8 bits per bank)
//   *_wb                      registered MEM/WB outputs
//   leds                      LED bank registers (8 bits per bank)
module memory_stage_pipelined #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned DM_WORDS = 1024,
    parameter int unsigned N_LED    = 1,
    parameter int unsigned N_SW     = 1,
    parameter logic [31:0] IO_BASE  = 32'h0000_F000
) (
    input  logic                  clk_me,
    input  logic                  rst_n_me,
    input  logic                  valid_me,
    input  logic                  stall_me,
    input  logic                  flush_me,
    input  logic [XLEN-1:0]       pc_next_me,
    input  logic [XLEN-1:0]       ALU_res_me,
    input  logic [XLEN-1:0]       RU_rs2_me,
    input  logic [4:0]            rd_me,
    input  logic [2:0]            dm_ctrl_me,
    input  logic [1:0]            RU_DM_write_src_me,
    input  logic                  RUwrite_me,
    input  logic                  dm_wr_me,
    input  logic [8*N_SW-1:0]     switches,
    output logic [XLEN-1:0]       pc_next_wb,
    output logic [XLEN-1:0]       ALU_res_wb,
    output logic [XLEN-1:0]       DM_data_rd_wb,
    output logic [4:0]            rd_wb,
    output logic [1:0]            RU_DM_write_src_wb,
    output logic                  RUwrite_wb,
    output logic                  valid_wb,
    output logic                  misalign_wb,
    output logic                  bus_err_wb,
    output logic [8*N_LED-1:0]    leds
);

    localparam int unsigned DM_BYTES = 4 * DM_WORDS;
    localparam int unsigned AW       = $clog2(DM_BYTES);
    localparam int unsigned IW       = AW - 2;
    localparam int unsigned NB       = XLEN / 8;
    localparam logic [1:0]  SRC_DM   = 2'b01;
    localparam logic [31:0] SW_OFS   = 32'h0000_0040;

    logic [XLEN-1:0]   mem [DM_WORDS];
    logic [8*N_SW-1:0] sw_meta;
    logic [8*N_SW-1:0] sw_sync;

    logic              is_load_c;
    logic              access_c;
    logic              dm_hit_c;
    logic [N_LED-1:0]  led_hit_c;
    logic [N_SW-1:0]   sw_hit_c;
    logic              io_hit_c;
    logic              misalign_c;
    logic              bus_err_c;
    logic              commit_c;
    logic              store_c;
    logic              dm_we_c;
    logic              led_we_c;
    logic [IW-1:0]     dm_idx_c;
    logic [NB-1:0]     be_c;
    logic [XLEN-1:0]   wdata_c;
    logic [XLEN-1:0]   io_rd_c;
    logic [XLEN-1:0]   rd_word_c;
    logic [XLEN-1:0]   shifted_c;
    logic [XLEN-1:0]   load_data_c;

    // Address decode and access classification
    assign is_load_c = (RU_DM_write_src_me == SRC_DM);
    assign access_c  = valid_me & (dm_wr_me | is_load_c);
    assign dm_hit_c  = (ALU_res_me < XLEN'(DM_BYTES));
    assign dm_idx_c  = ALU_res_me[AW-1:2];

    always_comb begin
        led_hit_c = '0;
        sw_hit_c  = '0;
        for (int k = 0; k < int'(N_LED); k++) begin
            led_hit_c[k] = (ALU_res_me == XLEN'(IO_BASE + 32'(4 * k)));
        end
        for (int k = 0; k < int'(N_SW); k++) begin
            sw_hit_c[k] = (ALU_res_me == XLEN'(IO_BASE + SW_OFS + 32'(4 * k)));
        end
    end

    assign io_hit_c  = (|led_hit_c) | (|sw_hit_c);
    assign bus_err_c = access_c & ~(dm_hit_c | io_hit_c);

    // Natural alignment check: halves on even addresses, words on multiples of four
    always_comb begin
        misalign_c = 1'b0;
        case (dm_ctrl_me[1:0])
            2'b01:   misalign_c = ALU_res_me[0];
            2'b10:   misalign_c = (ALU_res_me[1:0] != 2'b00);
            default: misalign_c = 1'b0;
        endcase
        misalign_c = misalign_c & access_c;
    end

    // A store takes effect only for a live, unstalled, unflushed, aligned instruction
    assign commit_c = valid_me & ~stall_me & ~flush_me;
    assign store_c  = commit_c & dm_wr_me & ~misalign_c;
    assign dm_we_c  = store_c & dm_hit_c;
    assign led_we_c = store_c;

    // Store lane steering: replicate the data across the word, enable the addressed lanes
    always_comb begin
        be_c    = '0;
        wdata_c = RU_rs2_me;
        case (dm_ctrl_me[1:0])
            2'b00: begin
                wdata_c = {NB{RU_rs2_me[7:0]}};
                be_c    = NB'(1) << ALU_res_me[1:0];
            end
            2'b01: begin
                wdata_c = {(NB/2){RU_rs2_me[15:0]}};
                be_c    = ALU_res_me[1] ? NB'(4'b1100) : NB'(4'b0011);
            end
            default: begin
                wdata_c = RU_rs2_me;
                be_c    = '1;
            end
        endcase
    end

    // IO read mux: LEDs read back, switches return the synchronised value
    always_comb begin
        io_rd_c = '0;
        for (int k = 0; k < int'(N_LED); k++) begin
            if (led_hit_c[k]) begin
                io_rd_c = io_rd_c | XLEN'(leds[8*k +: 8]);
            end
        end
        for (int k = 0; k < int'(N_SW); k++) begin
            if (sw_hit_c[k]) begin
                io_rd_c = io_rd_c | XLEN'(sw_sync[8*k +: 8]);
            end
        end
    end

    // Word read; the memory is read at the capturing edge, so an earlier store is already visible
    always_comb begin
        rd_word_c = '0;
        if (dm_hit_c) begin
            rd_word_c = mem[dm_idx_c];
        end else if (io_hit_c) begin
            rd_word_c = io_rd_c;
        end
    end

    // Load extraction: shift the addressed lane down, then sign- or zero-extend
    assign shifted_c = rd_word_c >> {ALU_res_me[1:0], 3'b000};

    always_comb begin
        load_data_c = rd_word_c;
        case (dm_ctrl_me)
            3'b000:  load_data_c = {{(XLEN-8){shifted_c[7]}}, shifted_c[7:0]};
            3'b001:  load_data_c = {{(XLEN-16){shifted_c[15]}}, shifted_c[15:0]};
            3'b100:  load_data_c = XLEN'(shifted_c[7:0]);
            3'b101:  load_data_c = XLEN'(shifted_c[15:0]);
            default: load_data_c = rd_word_c;
        endcase
        if (misalign_c) begin
            load_data_c = '0;
        end
    end

    // Data memory array (contents are not reset)
    always_ff @(posedge clk_me) begin
        for (int b = 0; b < int'(NB); b++) begin
            if (dm_we_c && be_c[b]) begin
                mem[dm_idx_c][8*b +: 8] <= wdata_c[8*b +: 8];
            end
        end
    end

    // Two-flop switch synchroniser
    always_ff @(posedge clk_me or negedge rst_n_me) begin
        if (!rst_n_me) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= switches;
            sw_sync <= sw_meta;
        end
    end

    // LED banks take the low byte of the store data
    always_ff @(posedge clk_me or negedge rst_n_me) begin
        if (!rst_n_me) begin
            leds <= '0;
        end else begin
            for (int k = 0; k < int'(N_LED); k++) begin
                if (led_we_c && led_hit_c[k]) begin
                    leds[8*k +: 8] <= RU_rs2_me[7:0];
                end
            end
        end
    end

    // MEM/WB register: flush beats stall; an invalid instruction becomes a bubble
    always_ff @(posedge clk_me or negedge rst_n_me) begin
        if (!rst_n_me) begin
            pc_next_wb         <= '0;
            ALU_res_wb         <= '0;
            DM_data_rd_wb      <= '0;
            rd_wb              <= '0;
            RU_DM_write_src_wb <= '0;
            RUwrite_wb         <= 1'b0;
            valid_wb           <= 1'b0;
            misalign_wb        <= 1'b0;
            bus_err_wb         <= 1'b0;
        end else if (flush_me || (!stall_me && !valid_me)) begin
            pc_next_wb         <= '0;
            ALU_res_wb         <= '0;
            DM_data_rd_wb      <= '0;
            rd_wb              <= '0;
            RU_DM_write_src_wb <= '0;
            RUwrite_wb         <= 1'b0;
            valid_wb           <= 1'b0;
            misalign_wb        <= 1'b0;
            bus_err_wb         <= 1'b0;
        end else if (!stall_me) begin
            pc_next_wb         <= pc_next_me;
            ALU_res_wb         <= ALU_res_me;
            DM_data_rd_wb      <= load_data_c;
            rd_wb              <= rd_me;
            RU_DM_write_src_wb <= RU_DM_write_src_me;
            RUwrite_wb         <= RUwrite_me & ~misalign_c;
            valid_wb           <= 1'b1;
            misalign_wb        <= misalign_c;
            bus_err_wb         <= bus_err_c;
        end
    end

endmodule

// File: doc/memory_stage_pipelined.md
Name: memory_stage_pipelined

Overview:
- Parametrised successor to the MEM stage of the 5-stage RISC-V pipeline. Sits between the EX/MEM and MEM/WB boundaries.
- Owns the MEM/WB pipeline register, which the previous pass-through stage did not have.
- Contains a synchronous-read data memory with byte/half/word access, N memory-mapped LED banks and N switch banks with 2-flop synchronisers.
- Adds stall/flush handling and misalignment and bus-error reporting to the WB stage.

Parameters:
- XLEN, 32, datapath width (32 only supported; parametrised for port widths).
- DM_WORDS, 1024, data memory depth in 32-bit words; power of two.
- N_LED, 1, number of 8-bit LED banks.
- N_SW, 1, number of 8-bit switch banks.
- IO_BASE, 32'h0000_F000, base address of the IO window (4 KiB aligned).

Ports:
- clk_me  in  1  stage clock, rising edge.
- rst_n_me  in  1  asynchronous, active-low reset.
- valid_me  in  1  instruction in MEM is valid.
- stall_me  in  1  hold MEM/WB register; suppress side effects.
- flush_me  in  1  insert bubble into WB.
- pc_next_me  in  XLEN  PC+4 from EX.
- ALU_res_me  in  XLEN  effective address / ALU result.
- RU_rs2_me  in  XLEN  store data.
- rd_me  in  5  destination register.
- dm_ctrl_me  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- RU_DM_write_src_me  in  2  WB mux select, passed through.
- RUwrite_me  in  1  register write enable.
- dm_wr_me  in  1  store enable.
- switches  in  8*N_SW  raw asynchronous switch inputs.
- pc_next_wb, ALU_res_wb, DM_data_rd_wb  out  XLEN  registered.
- rd_wb  out  5  registered.
- RU_DM_write_src_wb  out  2  registered.
- RUwrite_wb  out  1  registered.
- valid_wb  out  1  registered.
- misalign_wb  out  1  registered.
- bus_err_wb  out  1  registered.
- leds  out  8*N_LED  LED bank registers.

Behaviour:
- Reset (async, rst_n_me=0): every *_wb output = 0, leds = 0, synchroniser flops = 0. DM contents are not reset.
- Latency: 1 cycle. All *_wb outputs reflect the MEM inputs sampled at the previous rising edge. DM_data_rd_wb is aligned with the same edge.
- Address decode on ALU_res_me:
  - DM: addr < 4*DM_WORDS, index = addr[log2(4*DM_WORDS)-1:2].
  - LED bank k: addr == IO_BASE+4k, k<N_LED; read/write, byte lane 0.
  - Switch bank k: addr == IO_BASE+0x40+4k; read-only, synchronised value; writes ignored.
  - Any other address: read = 0, write ignored, bus_err_wb=1 if valid_me and (dm_wr_me or load).
  - "Load" = RU_DM_write_src_me selects DM (2'b01).
- Alignment: H requires addr[0]=0; W requires addr[1:0]=0.
  - Violation with a valid load/store: misalign_wb=1, store suppressed, DM_data_rd_wb=0.
  - RUwrite_wb forced 0.
- Store (SB/SH/SW): byte-enable write to the selected lane(s) at the rising edge when valid_me & dm_wr_me & !stall_me & !flush_me & aligned & DM-or-LED address.
  - LED stores take the low byte only.
- Load extraction: byte/half selected by addr[1:0]. B/H sign-extend; BU/HU zero-extend; W passes through.
- Stall (stall_me=1, flush_me=0): all WB registers, including DM_data_rd_wb, hold. No DM/LED write.
- Flush (flush_me=1): takes priority over stall. Next cycle valid_wb=0, RUwrite_wb=0, misalign_wb=0, bus_err_wb=0; other fields don't-care (implemented as 0). No write.
- valid_me=0: behaves like flush for side effects; the WB bubble propagates.
- Store at edge N followed by a load to the same address at edge N+1: the load returns the new data.
- Switches: two-flop synchroniser. A change is visible to a load issued 2 edges after the input changes.
- Reset asserted mid-store: the write at that edge is not guaranteed. LEDs are 0 immediately.

Test Plan:
- Reset, then SW 0xDEADBEEF to 0x10, then LW 0x10 -> DM_data_rd_wb=0xDEADBEEF one cycle after the load; then LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD.
- SB 0x55 to 0x11 over 0xDEADBEEF, then LW 0x10 -> 0xDEAD55EF; SH to 0x11 -> misalign_wb=1, RUwrite_wb=0, memory unchanged.
- SW 0xA5 to IO_BASE -> leds=0xA5 after the edge; switches=0x3C held, LW IO_BASE+0x40 two cycles later -> 0x0000003C.
- SW with stall_me=1 for 3 cycles, then released -> exactly one write, WB outputs frozen during the stall; same store with stall_me=flush_me=1 -> no write, valid_wb=0.
- LW to 0x8000_0000 -> bus_err_wb=1, DM_data_rd_wb=0; assert rst_n_me mid-stream -> all outputs and leds 0 asynchronously.
